cronometro_bcd: RTL and testbench
=================================

CRONOMETRO_BCD -- requirements
Module: cronometro_bcd

Interface
REQ-001 The block SHALL have parameter NDIG, default 4: the number of BCD digits, legal range 1..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on the rising edge of clk.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port tick_in, input, 1 bit: the divided-rate level from the upstream frequency divider, synchronous to clk.
REQ-005 The block SHALL have port start, input, 1 bit: a request to begin or resume counting, sampled each cycle.
REQ-006 The block SHALL have port stop, input, 1 bit: a request to pause counting, sampled each cycle.
REQ-007 The block SHALL have port clear, input, 1 bit: a request to zero the count and return to idle, sampled each cycle.
REQ-008 The block SHALL have port digits, output, 4*NDIG bits: the packed BCD count, with digit 0 (least significant) in bits [3:0].
REQ-009 The block SHALL have port running, output, 1 bit: high while the state machine is in RUN.
REQ-010 The block SHALL have port ovf, output, 1 bit: a one-cycle pulse on wrap-around.

Function
REQ-011 The block SHALL register tick_in into tick_q every cycle and form tick_rise = tick_in AND NOT tick_q; the block SHALL count only rising edges of tick_in, never levels.
REQ-012 The state machine SHALL have exactly three states: IDLE, RUN and PAUSE, with the state encoding internal to the block.
REQ-013 Transitions: clear SHALL move any state to IDLE; start SHALL move IDLE or PAUSE to RUN; stop SHALL move RUN to PAUSE.
REQ-014 When control inputs occur together, priority SHALL be clear > stop > start.
REQ-015 Any other combination of inputs SHALL leave the state unchanged.
REQ-016 In RUN with tick_rise high and no stop or clear in the same cycle, digits SHALL increment by one on that clock edge, giving zero-cycle latency from the tick_rise sample.
REQ-017 A tick_rise arriving in the same cycle as the start that leaves IDLE or PAUSE SHALL NOT be counted.
REQ-018 A tick_rise arriving in the same cycle as stop in RUN SHALL NOT be counted.
REQ-019 Increment rule: each digit SHALL count 0..9; a digit at 9 receiving a carry SHALL become 0 and propagate the carry to the next digit; no digit SHALL ever hold a value from 10 to 15.
REQ-020 Wrap-around: when every digit is 9 and an increment occurs, all digits SHALL become 0 and ovf SHALL be high for exactly the following cycle; counting SHALL continue in RUN.
REQ-021 clear SHALL zero digits on the same edge as the transition to IDLE.
REQ-022 In IDLE and PAUSE, digits SHALL hold their value.
REQ-023 running SHALL be a registered output equal to (state == RUN).

Reset
REQ-024 Assertion of rst_n low SHALL immediately force state to IDLE, digits to 0, tick_q to 0, running to 0 and ovf to 0, independent of clk.
REQ-025 Reset asserted mid-count SHALL discard the count; no partial increment SHALL be visible after deassertion.
REQ-026 On the first edge after rst_n deasserts, a tick_in that is already high SHALL be treated as a rising edge, because tick_q is 0; this event is harmless because the block is in IDLE.

Configuration
REQ-027 Macro CRONOMETRO_BCD_LAP_EN, when defined, SHALL add port lap (input, 1 bit), port lap_val (output, 4*NDIG bits) and port lap_valid (output, 1 bit).
REQ-028 With CRONOMETRO_BCD_LAP_EN defined, a lap in RUN SHALL capture the digits value present before that edge's increment into lap_val and set lap_valid.
REQ-029 With CRONOMETRO_BCD_LAP_EN defined, clear or reset SHALL zero lap_val and lap_valid, and lap SHALL be ignored outside RUN.
REQ-030 With CRONOMETRO_BCD_LAP_EN undefined, the lap, lap_val and lap_valid ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Scenario: reset, pulse start, apply 12 tick_in rising edges -> digits = 0x0012 and running = 1.
REQ-032 Scenario: preload the count to 9999 via ticks, then one more tick -> digits = 0x0000, ovf high for exactly 1 cycle, running stays 1.
REQ-033 Scenario: in RUN at count 0x0005, assert stop in the same cycle as tick_rise -> digits stays 0x0005 and the state becomes PAUSE.
REQ-034 Scenario: in PAUSE at 0x0005, apply 3 ticks and then start -> digits stays 0x0005 until the first tick after start, then becomes 0x0006.
REQ-035 Scenario: assert start, stop and clear in one cycle at count 0x0042 -> next cycle digits = 0x0000, state IDLE, running = 0.
REQ-036 Scenario: drop rst_n low between clock edges at count 0x0123 -> digits = 0x0000 immediately, before the next clock edge.

Source files
------------

// File: rtl/cronometro_bcd.sv
// ---------------------------------------------------------------------------
// cronometro_bcd
//    BCD stopwatch counter. Counts rising edges of a divided-rate tick level
//    while running, with start / stop / clear control and a one-cycle wrap
//    pulse.
//
// Parameters
//    NDIG       number of BCD digits (1..8)
//
// Ports
//    clk        clock, all state updates on the rising edge
//    rst_n      asynchronous active-low reset
//    tick_in    divided-rate level, synchronous to clk; only rising edges count
//    start      begin / resume counting (IDLE or PAUSE -> RUN)
//    stop       pause counting (RUN -> PAUSE)
//    clear      zero the count and return to IDLE
//    digits     packed BCD count, digit 0 in bits [3:0]
//    running    registered, high while in RUN
//    ovf        one-cycle pulse after the count wraps from all-nines to zero
//
// Optional lap capture, enabled by defining CRONOMETRO_BCD_LAP_EN:
//    lap        capture request, honoured only in RUN
//    lap_val    count value present just before the capturing edge
//    lap_valid  set by a capture, cleared by clear or reset
// ---------------------------------------------------------------------------
module cronometro_bcd #(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick_in,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   output logic [4*NDIG-1:0] digits,
   output logic              running,
   output logic              ovf
`ifdef CRONOMETRO_BCD_LAP_EN
   ,
   input  logic              lap,
   output logic [4*NDIG-1:0] lap_val,
   output logic              lap_valid
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic                tick_q;
   logic                tick_rise;
   logic                inc;
   logic [4*NDIG-1:0]   digits_reg;
   logic [4*NDIG-1:0]   digits_inc;
   logic [NDIG:0]       carry;
   logic                running_reg;
   logic                ovf_reg;

   // Edge detect: a level held high across many cycles counts once.
   assign tick_rise = tick_in & ~tick_q;

   // Next-state logic; clear beats stop, stop beats start.
   // When stop is asserted, start is ignored even where stop has no effect.
   always_comb begin
      state_next = state_reg;
      inc        = 1'b0;
      if (clear) begin
         state_next = IDLE;
      end else if (stop) begin
         if (state_reg == RUN) begin
            state_next = PAUSE;
         end
      end else if (start) begin
         if (state_reg != RUN) begin
            state_next = RUN;
         end
      end
      // Only an edge seen while already in RUN counts; the edge that arrives
      // with the start that leaves IDLE/PAUSE is dropped, as is one with stop.
      if ((state_reg == RUN) && tick_rise && !stop && !clear) begin
         inc = 1'b1;
      end
   end

   // Ripple-carry BCD incrementer: each digit rolls 9 -> 0 and passes the
   // carry up. carry[NDIG] is high only when every digit was 9.
   assign carry[0] = inc;

   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
         logic [3:0] d;
         assign d = digits_reg[4*gi +: 4];
         assign carry[gi+1] = carry[gi] && (d == 4'd9);
         assign digits_inc[4*gi +: 4] = !carry[gi]     ? d     :
                                        (d == 4'd9)    ? 4'd0  :
                                                         d + 4'd1;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         tick_q      <= 1'b0;
         digits_reg  <= '0;
         running_reg <= 1'b0;
         ovf_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         tick_q      <= tick_in;
         digits_reg  <= clear ? '0 : digits_inc;
         // Registered from next state so it always matches the current state.
         running_reg <= (state_next == RUN);
         ovf_reg     <= carry[NDIG];
      end
   end

   assign digits  = digits_reg;
   assign running = running_reg;
   assign ovf     = ovf_reg;

`ifdef CRONOMETRO_BCD_LAP_EN
   logic [4*NDIG-1:0] lap_val_reg;
   logic              lap_valid_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_val_reg   <= '0;
         lap_valid_reg <= 1'b0;
      end else if (clear) begin
         lap_val_reg   <= '0;
         lap_valid_reg <= 1'b0;
      end else if (lap && (state_reg == RUN)) begin
         // Pre-increment value: the count as displayed when lap was pressed.
         lap_val_reg   <= digits_reg;
         lap_valid_reg <= 1'b1;
      end
   end

   assign lap_val   = lap_val_reg;
   assign lap_valid = lap_valid_reg;
`endif

endmodule

// File: tb/tb_cronometro_bcd.sv
// ---------------------------------------------------------------------------
// tb_cronometro_bcd
//    Self-checking bench for cronometro_bcd (NDIG = 4). A behavioural model
//    keeps the count as a plain integer and the mode as a small number; every
//    cycle the DUT outputs are compared with the model. Directed scenarios
//    are followed by randomized control/tick traffic.
// ---------------------------------------------------------------------------
module tb_cronometro_bcd;

   localparam int NDIG = 4;
   localparam int MODV = 10000;   // 10**NDIG

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic              clk;
   logic              rst_n;
   logic              tick_in;
   logic              start;
   logic              stop;
   logic              clear;
   logic [4*NDIG-1:0] digits;
   logic              running;
   logic              ovf;
`ifdef CRONOMETRO_BCD_LAP_EN
   logic              lap;
   logic [4*NDIG-1:0] lap_val;
   logic              lap_valid;
`endif

   int checks;
   int errors;

   // reference model state
   int m_count;
   int m_mode;
   int m_prev_tick;
   int m_ovf;

   cronometro_bcd #(.NDIG(NDIG)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_in (tick_in),
      .start   (start),
      .stop    (stop),
      .clear   (clear),
      .digits  (digits),
      .running (running),
      .ovf     (ovf)
`ifdef CRONOMETRO_BCD_LAP_EN
      ,
      .lap       (lap),
      .lap_val   (lap_val),
      .lap_valid (lap_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < NDIG; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_count     = 0;
      m_mode      = M_IDLE;
      m_prev_tick = 0;
      m_ovf       = 0;
   endtask

   // One clock of the stopwatch rules, applied to the model.
   task automatic model_step(input int t, input int s, input int p, input int c);
      int edge_seen;
      edge_seen = (t != 0) && (m_prev_tick == 0);
      m_ovf = 0;
      if (c != 0) begin
         m_count = 0;
      end else if (m_mode == M_RUN && edge_seen && p == 0) begin
         if (m_count == MODV - 1) begin
            m_count = 0;
            m_ovf   = 1;
         end else begin
            m_count = m_count + 1;
         end
      end
      if (c != 0)                       m_mode = M_IDLE;
      else if (p != 0) begin
         if (m_mode == M_RUN)           m_mode = M_PAUSE;
      end else if (s != 0 && m_mode != M_RUN) m_mode = M_RUN;
      m_prev_tick = t;
   endtask

   task automatic compare_all();
      check("digits",  32'(digits),  to_bcd(m_count));
      check("running", 32'(running), 32'(m_mode == M_RUN));
      check("ovf",     32'(ovf),     32'(m_ovf));
   endtask

   // Drive one cycle of inputs, advance model at the edge, check 1 ns later.
   task automatic cyc(input logic t, input logic s, input logic p, input logic c);
      tick_in = t; start = s; stop = p; clear = c;
      @(posedge clk);
      model_step(int'(t), int'(s), int'(p), int'(c));
      #1;
      compare_all();
   endtask

   task automatic tick_pulse();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic restart_at(input int n);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) tick_pulse();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; tick_in = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
`ifdef CRONOMETRO_BCD_LAP_EN
      lap = 1'b0;
`endif
      model_reset();
      #12;
      check("reset_digits",  32'(digits),  32'h0);
      check("reset_running", 32'(running), 32'h0);
      check("reset_ovf",     32'(ovf),     32'h0);
      rst_n = 1'b1;

      // 12 counted edges after start
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) tick_pulse();
      check("s12_digits",  32'(digits),  32'h0012);
      check("s12_running", 32'(running), 32'h1);

      // held-high level counts once
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("level_once", 32'(digits), 32'h0013);

      // run up to 9999, then wrap
      for (int i = 13; i < 9999; i++) tick_pulse();
      check("pre_wrap", 32'(digits), 32'h9999);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("wrap_digits",  32'(digits),  32'h0000);
      check("wrap_ovf",     32'(ovf),     32'h1);
      check("wrap_running", 32'(running), 32'h1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("wrap_ovf_drop", 32'(ovf), 32'h0);

      // stop together with tick edge at 5
      restart_at(5);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      check("stop_tick_digits",  32'(digits),  32'h0005);
      check("stop_tick_running", 32'(running), 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // ticks in PAUSE are ignored; first tick after start counts
      for (int i = 0; i < 3; i++) tick_pulse();
      check("pause_hold", 32'(digits), 32'h0005);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("resume_digits",  32'(digits),  32'h0005);
      check("resume_running", 32'(running), 32'h1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("resume_tick", 32'(digits), 32'h0006);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // tick edge together with the start that leaves PAUSE is dropped
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      check("start_tick_drop", 32'(digits), 32'h0006);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // all controls together at 42
      restart_at(42);
      check("pre_all", 32'(digits), 32'h0042);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      check("all_digits",  32'(digits),  32'h0000);
      check("all_running", 32'(running), 32'h0);

      // asynchronous reset between edges at 123
      restart_at(123);
      check("pre_rst", 32'(digits), 32'h0123);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_digits",  32'(digits),  32'h0000);
      check("async_running", 32'(running), 32'h0);
      model_reset();
      #3;
      rst_n = 1'b1;
      // tick already high at first edge: treated as an edge, but IDLE
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("post_rst_hold", 32'(digits), 32'h0000);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic t, s, p, c;
         t = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 99) < 12);
         p = ($urandom_range(0, 99) < 5);
         c = ($urandom_range(0, 99) < 2);
         cyc(t, s, p, c);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
